ifu_fetch_ctrl: RTL
===================

Name: ifu_fetch_ctrl

Overview:
- Fetch sequencer between the PC/next-PC logic and the instruction memory port.
- Owns the fetch PC and issues one instruction-memory request at a time using a req/gnt/rvalid handshake.
- Holds the returned instruction in a one-entry output register with valid/ready toward decode.
- Applies branch/jump redirects and discards any wrong-path response still in flight.

Parameters:
- XLEN, 32, address and instruction width.
- RESET_PC, 32'h80000000, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset; rst=0 clears all state immediately.
- redirect_i  in  1  one-cycle redirect strobe from the branch/jump unit.
- redirect_pc_i  in  XLEN  redirect target; bits [1:0] ignored and forced to 0.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  XLEN  fetch address; memory samples it only on req&gnt.
- imem_gnt_i  in  1  memory accepts the request this cycle.
- imem_rvalid_i  in  1  response data valid.
- imem_rdata_i  in  XLEN  response instruction.
- inst_valid_o  out  1  instruction available to decode.
- inst_o  out  XLEN  instruction.
- inst_pc_o  out  XLEN  PC of inst_o.
- inst_ready_i  in  1  decode consumes the instruction on inst_valid_o&inst_ready_i.

Behaviour:
- States are IDLE, REQ, WAIT, OUT.
- Registers are pc_q (next fetch PC), fpc_q (PC of the outstanding request), kill_q, inst_q and ipc_q.
- Reset (rst=0): state=IDLE, pc_q=RESET_PC, fpc_q=0, kill_q=0, inst_q=0, ipc_q=0.
  - Outputs during reset: imem_req_o=0, imem_addr_o=pc_q, inst_valid_o=0, inst_o=0, inst_pc_o=0.
- IDLE: on the first clock edge with rst=1, go to REQ.
- REQ: imem_req_o=1, imem_addr_o=pc_q.
  - On gnt: fpc_q<=pc_q, pc_q<=pc_q+4, go to WAIT.
- WAIT: imem_req_o=0.
  - On rvalid with kill_q=0: inst_q<=rdata, ipc_q<=fpc_q, go to OUT.
  - On rvalid with kill_q=1: drop the data, kill_q<=0, go to REQ.
- OUT: inst_valid_o=1, inst_o=inst_q, inst_pc_o=ipc_q.
  - On inst_ready_i: go to REQ.
  - inst_valid_o never drops without a handshake, except on redirect.
- Latency: req→gnt→rvalid→valid. The minimum is one instruction every 3 cycles when gnt and rvalid each arrive one cycle after the preceding step; throughput is not a goal of this block.
- Redirect takes priority over every other event in the same cycle.
  - IDLE: pc_q<=target.
  - REQ without gnt: pc_q<=target; imem_addr_o shows the target on the next cycle.
  - REQ with gnt in the same cycle: the old address is accepted; pc_q<=target, kill_q<=1, go to WAIT.
  - WAIT without rvalid: pc_q<=target, kill_q<=1.
  - WAIT with rvalid in the same cycle: drop the data, pc_q<=target, kill_q<=0, go to REQ.
  - OUT: discard the held instruction even if inst_ready_i=1 (wrong path); pc_q<=target, go to REQ.
- Back-to-back redirects: the latest target wins; at most one kill is pending.
- PC arithmetic is modulo 2^XLEN: 32'hFFFFFFFC+4 = 0.
- imem_rvalid_i outside WAIT is ignored, including a stale response after a mid-operation reset.
- imem_gnt_i while imem_req_o=0 is ignored.
- Reset asserted mid-transaction: state is cleared asynchronously; any outstanding response is dropped.

Decomposition:
- The shared package holds:
  - XLEN;
  - RESET_PC (32'h80000000);
  - the PC increment constant (4);
  - the state encoding IDLE=2'd0, REQ=2'd1, WAIT=2'd2, OUT=2'd3.
- One sub-module is natural: ifu_out_reg, the one-entry valid/ready holding register (inst_q/ipc_q plus flush input).
- The FSM, pc_q and kill logic stay in the top.

Test Plan:
1. Reset release, gnt and rvalid both held at 1, ready held at 1, rdata=32'h00000013 → imem_addr_o sequence 80000000, 80000004, 80000008; each instruction reaches inst_pc_o with matching PC; one instruction every 3 cycles.
2. Gnt delayed 3 cycles, ready held at 0 for 5 cycles in OUT → imem_addr_o stays stable until gnt; inst_valid_o held at 1 with unchanged inst_o/inst_pc_o until ready.
3. Redirect to 80001002 while in WAIT, then rvalid → response dropped, inst_valid_o stays 0; next request address is 80001000 and inst_pc_o=80001000 follows.
4. Redirect in the same cycle as gnt (old address 80000008, target 80000100) → response for 80000008 dropped; next imem_addr_o=80000100.
5. Redirect in OUT with inst_ready_i=1 → held instruction not delivered; inst_valid_o=0 next cycle; fetch restarts at the target.
6. pc_q=FFFFFFFC fetched, then async rst=0 mid-WAIT and stale rvalid after release → next PC wraps to 00000000; after reset, outputs return to reset values immediately, the stale response is ignored, and fetch restarts at 80000000.

Source files
------------

// File: rtl/ifu_fetch_ctrl_pkg.sv
// ifu_fetch_ctrl_pkg: shared widths, reset PC, PC step and fetch FSM encoding.
package ifu_fetch_ctrl_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_e;

endpackage

// File: rtl/ifu_out_reg.sv
// ifu_out_reg: one-entry valid/ready holding register for the fetched instruction and its PC.
module ifu_out_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic            ready,
    input  logic [XLEN-1:0] data,
    input  logic [XLEN-1:0] pc,
    output logic            valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid   <= 1'b0;
            inst    <= '0;
            inst_pc <= '0;
        end else begin
            valid <= load | (valid & ~ready & ~flush);
            if (load) begin
                inst    <= data;
                inst_pc <= pc;
            end
        end
    end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: single-outstanding instruction fetch sequencer with redirect and
// wrong-path response killing.
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int XLEN = ifu_fetch_ctrl_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = ifu_fetch_ctrl_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i
);

    state_e state_q, state_d;
    logic [XLEN-1:0] pc_q, fpc_q, target;
    logic kill_q, acc, rsp;

    assign target = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign acc = (state_q == REQ) & imem_gnt_i;
    assign rsp = (state_q == WAIT) & imem_rvalid_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            fpc_q   <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= redirect_i ? target : acc ? pc_q + PC_INC : pc_q;
            if (acc)
                fpc_q <= pc_q;
            // A redirect with a request already accepted must kill its response
            kill_q  <= rsp ? 1'b0 : (redirect_i & (acc | (state_q == WAIT))) ? 1'b1 : kill_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ:  state_d = imem_gnt_i ? WAIT : REQ;
            WAIT: state_d = !imem_rvalid_i ? WAIT : (kill_q | redirect_i) ? REQ : OUT;
            OUT:  state_d = (inst_ready_i | redirect_i) ? REQ : OUT;
        endcase
    end

    always_comb begin
        imem_req_o  = (state_q == REQ);
        imem_addr_o = pc_q;
    end

    ifu_out_reg #(.XLEN(XLEN)) u_out (
        .clk     (clk),
        .rst     (rst),
        .load    (rsp & ~kill_q & ~redirect_i),
        .flush   (redirect_i),
        .ready   (inst_ready_i),
        .data    (imem_rdata_i),
        .pc      (fpc_q),
        .valid   (inst_valid_o),
        .inst    (inst_o),
        .inst_pc (inst_pc_o)
    );

endmodule
